lbp_channel_scheduler: RTL and testbench

- Shares one LBP comparison/shift datapath between NUM_CHANNELS independent sample streams, e.g. several electrode/sensor channels feeding the preprocessor.
- Keeps per-channel LBP context (previous sample, partial code, bit counter) in a register bank and grants one channel per cycle with round-robin arbitration.
- Emits each completed CODESIZE-bit code, tagged with its channel index, through a 1-entry valid/ready output register.

---
 rtl/lbp_pkg.sv | 13 +
 rtl/lbp_rr_arbiter.sv | 64 ++++++
 rtl/lbp_channel_scheduler.sv | 138 +++++++++++++
 tb/tb_lbp_channel_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared helpers for the LBP channel scheduler and its arbiter.
// Contents:
//   chan_idx_w(n) - width of an index that addresses n items (minimum 1 bit)
// The context and output struct types depend on module parameters, so they
// are declared inside the modules that use them. Their widths are derived
// with chan_idx_w.
package lbp_pkg;

  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lbp_rr_arbiter.sv
// Parametric round-robin arbiter.
// Each cycle it grants the first requester at or above the rotating pointer,
// wrapping from N-1 back to 0. After a grant the pointer moves to the slot
// just past the winner. With no grant the pointer holds.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clear_i        - synchronous return of the pointer to 0
//   req_i          - request vector
//   gnt_o          - one-hot grant (or zero), combinational
//   gnt_idx_o      - index of the granted requester (0 when none)
//   gnt_any_o      - a grant is issued this cycle
module lbp_rr_arbiter
  import lbp_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = chan_idx_w(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // pos is one bit wider than an index so ptr+k can be wrapped by a single
  // subtraction. This also works when N is not a power of two.
  always_comb begin
    logic [IDX_W:0] pos;
    logic           found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found                     = 1'b1;
        gnt_o[pos[IDX_W-1:0]]     = 1'b1;
        gnt_idx_o                 = pos[IDX_W-1:0];
      end
    end
    gnt_any_o = found;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (gnt_any_o) begin
      ptr_d = (gnt_idx_o == IDX_W'(N-1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lbp_channel_scheduler.sv
// Time-shares one LBP compare/shift datapath across NUM_CHANNELS sample streams.
// Each channel keeps its own context: previous sample, partial code and bit
// count. One channel is granted per cycle by round-robin arbitration. Each
// completed CODESIZE-bit code is emitted with its channel index through a
// 1-entry valid/ready output register.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   clear_i            - synchronous clear of contexts, rr pointer and output
//   en_i               - grant enable; the output register drains regardless
//   data_i, valid_i    - per-channel samples
//   ready_o            - per-channel accept, one-hot or zero
//   code_o, chan_o     - completed code and its channel index
//   code_valid_o       - output valid
//   code_ready_i       - output ready
module lbp_channel_scheduler
  import lbp_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CODESIZE     = 6,
  parameter int DATA_WIDTH   = 32,
  localparam int CHAN_W      = chan_idx_w(NUM_CHANNELS)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    clear_i,
  input  logic                                    en_i,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data_i,
  input  logic [NUM_CHANNELS-1:0]                 valid_i,
  output logic [NUM_CHANNELS-1:0]                 ready_o,
  output logic [CODESIZE-1:0]                     code_o,
  output logic [CHAN_W-1:0]                       chan_o,
  output logic                                    code_valid_o,
  input  logic                                    code_ready_i
);

  localparam int              CNT_W    = chan_idx_w(CODESIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CODESIZE-1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] prev;
    logic [CODESIZE-1:0]   code;
    logic [CNT_W-1:0]      cnt;
  } lbp_ctx_t;

  typedef struct packed {
    logic [CODESIZE-1:0] code;
    logic [CHAN_W-1:0]   chan;
  } lbp_out_t;

  lbp_ctx_t ctx_q [NUM_CHANNELS];
  lbp_ctx_t ctx_d [NUM_CHANNELS];
  lbp_out_t out_q, out_d;
  logic     out_valid_q, out_valid_d;

  logic [NUM_CHANNELS-1:0] req;
  logic [NUM_CHANNELS-1:0] gnt;
  logic [CHAN_W-1:0]       gnt_idx;
  logic                    gnt_any;
  logic                    slot_free;
  logic [CODESIZE-1:0]     code_shift [NUM_CHANNELS];

  assign slot_free = !out_valid_q || code_ready_i;

  // A channel about to complete a code may only go when the output slot can
  // take it. Gating with rst_ni keeps ready_o low while reset is held.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      req[i] = rst_ni && valid_i[i] && en_i && !clear_i &&
               ((ctx_q[i].cnt != CNT_LAST) || slot_free);
    end
  end

  lbp_rr_arbiter #(
    .N (NUM_CHANNELS)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .req_i     (req),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign ready_o = gnt;

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      code_shift[i] = {ctx_q[i].code[CODESIZE-2:0], (data_i[i] > ctx_q[i].prev)};
    end
  end

  always_comb begin
    ctx_d       = ctx_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (clear_i) begin
      for (int i = 0; i < NUM_CHANNELS; i++) ctx_d[i] = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && code_ready_i) out_valid_d = 1'b0;
      // A reload in the same cycle overrides the drain above.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (gnt[i]) begin
          ctx_d[i].code = code_shift[i];
          ctx_d[i].prev = data_i[i];
          if (ctx_q[i].cnt == CNT_LAST) begin
            ctx_d[i].cnt = '0;
            out_d.code   = code_shift[i];
            out_d.chan   = gnt_idx;
            out_valid_d  = 1'b1;
          end else begin
            ctx_d[i].cnt = ctx_q[i].cnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CHANNELS; i++) ctx_q[i] <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ctx_q       <= ctx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign code_o       = out_q.code;
  assign chan_o       = out_q.chan;
  assign code_valid_o = out_valid_q;

endmodule

// File: tb/tb_lbp_channel_scheduler.sv
module tb_lbp_channel_scheduler;
  localparam int N  = 4;
  localparam int CS = 6;
  localparam int DW = 32;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                clear_i;
  logic                en_i;
  logic [N-1:0][DW-1:0] data_i;
  logic [N-1:0]        valid_i;
  logic [N-1:0]        ready_o;
  logic [CS-1:0]       code_o;
  logic [1:0]          chan_o;
  logic                code_valid_o;
  logic                code_ready_i;

  int checks = 0;
  int errors = 0;

  // reference model: per-channel history as plain integers
  logic [DW-1:0] m_prev [N];
  int            m_code [N];
  int            m_cnt  [N];
  int            m_ptr;
  bit            m_valid;
  int            m_out_code;
  int            m_out_chan;

  lbp_channel_scheduler #(
    .NUM_CHANNELS (N),
    .CODESIZE     (CS),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .en_i         (en_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .code_o       (code_o),
    .chan_o       (chan_o),
    .code_valid_o (code_valid_o),
    .code_ready_i (code_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_prev[c] = '0;
      m_code[c] = 0;
      m_cnt[c]  = 0;
    end
    m_ptr      = 0;
    m_valid    = 1'b0;
    m_out_code = 0;
    m_out_chan = 0;
  endtask

  function automatic logic [N-1:0] exp_grant();
    bit free;
    int c;
    if (!en_i || clear_i) return '0;
    free = !m_valid || code_ready_i;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (valid_i[c] && (m_cnt[c] != CS-1 || free)) return N'(1) << c;
    end
    return '0;
  endfunction

  // advance one clock; the model takes the same inputs the DUT sees
  task automatic tick();
    logic [N-1:0] g;
    bit loaded;
    int b;
    g = exp_grant();
    @(posedge clk_i);
    if (clear_i) begin
      model_reset();
    end else begin
      loaded = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (g[c]) begin
          b = (data_i[c] > m_prev[c]) ? 1 : 0;
          m_code[c] = ((m_code[c] << 1) | b) & ((1 << CS) - 1);
          m_prev[c] = data_i[c];
          m_ptr     = (c + 1) % N;
          if (m_cnt[c] == CS-1) begin
            m_cnt[c]   = 0;
            m_out_code = m_code[c];
            m_out_chan = c;
            loaded     = 1'b1;
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
        end
      end
      if (loaded) m_valid = 1'b1;
      else if (m_valid && code_ready_i) m_valid = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; en_i = 1'b1; code_ready_i = 1'b1;
    valid_i = '1;
    for (int c = 0; c < N; c++) data_i[c] = DW'(c + 1);
    model_reset();
    #1;
    checks++;
    if (ready_o !== '0) begin errors++; $display("FAIL reset_ready got %b want 0000", ready_o); end
    @(negedge clk_i); @(negedge clk_i);
    checks++;
    if (code_valid_o !== 1'b0 || code_o !== '0 || chan_o !== '0 || ready_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b code=%h chan=%0d rdy=%b want all 0", code_valid_o, code_o, chan_o, ready_o);
    end
    valid_i = '0;
    rst_ni  = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_ch0_basic();
    int s [6] = '{1, 3, 2, 5, 5, 7};
    clear_i = 1'b1; valid_i = '0; code_ready_i = 1'b1; en_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      valid_i = 4'b0001;
      data_i[0] = DW'(s[k]);
      #1;
      checks++;
      if (ready_o !== 4'b0001 || code_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL ch0_step%0d got rdy=%b v=%b want rdy=0001 v=0", k, ready_o, code_valid_o);
      end
      tick();
    end
    valid_i = '0;
    #1;
    checks++;
    if (code_valid_o !== 1'b1 || code_o !== 6'h35 || chan_o !== 2'd0) begin
      errors++;
      $display("FAIL ch0_code got v=%b code=%h chan=%0d want v=1 code=35 chan=0", code_valid_o, code_o, chan_o);
    end
    tick();
    #1;
    checks++;
    if (code_valid_o !== 1'b0) begin errors++; $display("FAIL ch0_pulse got v=%b want 0", code_valid_o); end
    tick();
  endtask

  task automatic test_all_channels();
    clear_i = 1'b1; valid_i = '0; code_ready_i = 1'b1;
    tick();
    clear_i = 1'b0;
    valid_i = '1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      for (int c = 0; c < N; c++) data_i[c] = DW'(cyc);
      #1;
      checks++;
      if (ready_o !== exp_grant() || ready_o !== 4'(1 << ((cyc - 1) % 4))) begin
        errors++;
        $display("FAIL all_grant cyc %0d got %b want %b", cyc, ready_o, exp_grant());
      end
      checks++;
      if (code_valid_o !== m_valid || code_o !== CS'(m_out_code) || chan_o !== 2'(m_out_chan)) begin
        errors++;
        $display("FAIL all_out cyc %0d got v=%b %h/%0d want v=%b %h/%0d", cyc, code_valid_o, code_o, chan_o, m_valid, m_out_code, m_out_chan);
      end
      if (cyc >= 22 && cyc <= 25) begin
        checks++;
        if (code_valid_o !== 1'b1 || code_o !== 6'h3F || chan_o !== 2'(cyc - 22)) begin
          errors++;
          $display("FAIL all_complete cyc %0d got v=%b %h/%0d want v=1 3f/%0d", cyc, code_valid_o, code_o, chan_o, cyc - 22);
        end
      end
      if (cyc == 21 || cyc == 26) begin
        checks++;
        if (code_valid_o !== 1'b0) begin errors++; $display("FAIL all_idle cyc %0d got v=%b want 0", cyc, code_valid_o); end
      end
      tick();
    end
    valid_i = '0;
  endtask

  task automatic test_backpressure();
    clear_i = 1'b1; valid_i = '0; code_ready_i = 1'b0;
    tick();
    clear_i = 1'b0;
    valid_i = '1;
    for (int cyc = 1; cyc <= 52; cyc++) begin
      for (int c = 0; c < N; c++) data_i[c] = DW'(cyc + 100);
      if (cyc == 41) code_ready_i = 1'b1;
      #1;
      checks++;
      if (ready_o !== exp_grant()) begin
        errors++;
        $display("FAIL bp_grant cyc %0d got %b want %b", cyc, ready_o, exp_grant());
      end
      checks++;
      if (code_valid_o !== m_valid || code_o !== CS'(m_out_code) || chan_o !== 2'(m_out_chan)) begin
        errors++;
        $display("FAIL bp_out cyc %0d got v=%b %h/%0d want v=%b %h/%0d", cyc, code_valid_o, code_o, chan_o, m_valid, m_out_code, m_out_chan);
      end
      if (cyc >= 22 && cyc <= 41) begin
        checks++;
        if (code_valid_o !== 1'b1 || code_o !== 6'h3F || chan_o !== 2'd0) begin
          errors++;
          $display("FAIL bp_hold cyc %0d got v=%b %h/%0d want v=1 3f/0", cyc, code_valid_o, code_o, chan_o);
        end
      end
      tick();
    end
    valid_i = '0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_unsigned();
    logic [DW-1:0] s [6] = '{32'hFFFF_FFFF, 32'h0, 32'd7, 32'd7, 32'd8, 32'd1};
    clear_i = 1'b1; valid_i = '0; code_ready_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      valid_i = 4'b0010;
      data_i[1] = s[k];
      #1;
      checks++;
      if (ready_o !== 4'b0010) begin errors++; $display("FAIL uns_step%0d got %b want 0010", k, ready_o); end
      tick();
    end
    valid_i = '0;
    #1;
    checks++;
    if (code_valid_o !== 1'b1 || code_o !== 6'h2A || chan_o !== 2'd1) begin
      errors++;
      $display("FAIL uns_code got v=%b %h/%0d want v=1 2a/1", code_valid_o, code_o, chan_o);
    end
    tick();
  endtask

  task automatic test_clear();
    int s [6] = '{5, 6, 2, 9, 9, 1};
    clear_i = 1'b1; valid_i = '0; code_ready_i = 1'b0;
    tick();
    clear_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      valid_i = 4'b0001; data_i[0] = DW'(k + 1);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      valid_i = 4'b0100; data_i[2] = DW'(9 - k);
      #1;
      checks++;
      if (ready_o !== 4'b0100) begin errors++; $display("FAIL clr_pre%0d got %b want 0100", k, ready_o); end
      tick();
    end
    #1;
    checks++;
    if (code_valid_o !== 1'b1) begin errors++; $display("FAIL clr_pending got v=%b want 1", code_valid_o); end
    clear_i = 1'b1; data_i[2] = 32'd50;
    #1;
    checks++;
    if (ready_o !== '0) begin errors++; $display("FAIL clr_ready got %b want 0000", ready_o); end
    tick();
    clear_i = 1'b0;
    #1;
    checks++;
    if (code_valid_o !== 1'b0) begin errors++; $display("FAIL clr_drop got v=%b want 0", code_valid_o); end
    code_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      valid_i = 4'b0100; data_i[2] = DW'(s[k]);
      #1;
      checks++;
      if (ready_o !== 4'b0100) begin errors++; $display("FAIL clr_post%0d got %b want 0100", k, ready_o); end
      tick();
    end
    valid_i = '0;
    #1;
    checks++;
    if (code_valid_o !== 1'b1 || code_o !== 6'h34 || chan_o !== 2'd2) begin
      errors++;
      $display("FAIL clr_code got v=%b %h/%0d want v=1 34/2", code_valid_o, code_o, chan_o);
    end
    tick();
  endtask

  task automatic test_enable();
    clear_i = 1'b1; valid_i = '0; code_ready_i = 1'b1; en_i = 1'b1;
    tick();
    clear_i = 1'b0;
    valid_i = '1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      en_i = !(cyc >= 7 && cyc < 17);
      for (int c = 0; c < N; c++) data_i[c] = DW'($urandom_range(0, 15));
      #1;
      if (!en_i) begin
        checks++;
        if (ready_o !== '0) begin errors++; $display("FAIL en_off cyc %0d got %b want 0000", cyc, ready_o); end
      end
      checks++;
      if (ready_o !== exp_grant()) begin
        errors++;
        $display("FAIL en_grant cyc %0d got %b want %b", cyc, ready_o, exp_grant());
      end
      checks++;
      if (code_valid_o !== m_valid || code_o !== CS'(m_out_code) || chan_o !== 2'(m_out_chan)) begin
        errors++;
        $display("FAIL en_out cyc %0d got v=%b %h/%0d want v=%b %h/%0d", cyc, code_valid_o, code_o, chan_o, m_valid, m_out_code, m_out_chan);
      end
      tick();
    end
    en_i = 1'b1; valid_i = '0;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 800; cyc++) begin
      valid_i      = N'($urandom_range(0, 15));
      code_ready_i = ($urandom_range(0, 9) < 6);
      en_i         = ($urandom_range(0, 9) != 0);
      clear_i      = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < N; c++)
        data_i[c] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 7));
      #1;
      checks++;
      if (ready_o !== exp_grant()) begin
        errors++;
        $display("FAIL rnd_grant cyc %0d got %b want %b", cyc, ready_o, exp_grant());
      end
      checks++;
      if (code_valid_o !== m_valid || code_o !== CS'(m_out_code) || chan_o !== 2'(m_out_chan)) begin
        errors++;
        $display("FAIL rnd_out cyc %0d got v=%b %h/%0d want v=%b %h/%0d", cyc, code_valid_o, code_o, chan_o, m_valid, m_out_code, m_out_chan);
      end
      tick();
    end
    clear_i = 1'b0; en_i = 1'b1; valid_i = '0; code_ready_i = 1'b1;
  endtask

  task automatic test_async_reset();
    clear_i = 1'b1; valid_i = '0; code_ready_i = 1'b0;
    tick();
    clear_i = 1'b0;
    valid_i = '1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      for (int c = 0; c < N; c++) data_i[c] = DW'(cyc);
      tick();
    end
    #1;
    checks++;
    if (code_valid_o !== 1'b1 || code_valid_o !== m_valid) begin
      errors++;
      $display("FAIL arst_pre got v=%b want 1", code_valid_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (ready_o !== '0 || code_valid_o !== 1'b0 || code_o !== '0 || chan_o !== '0) begin
      errors++;
      $display("FAIL arst_now got rdy=%b v=%b %h/%0d want all 0", ready_o, code_valid_o, code_o, chan_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    // contexts must be back at zero: first grant goes to channel 0
    #1;
    checks++;
    if (ready_o !== 4'b0001) begin errors++; $display("FAIL arst_ptr got %b want 0001", ready_o); end
    valid_i = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ch0_basic();
    test_all_channels();
    test_backpressure();
    test_unsigned();
    test_clear();
    test_enable();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
